status_reg: RTL and testbench

6502 processor-status (P) register for the CPU core, sitting directly downstream of the ALU. It captures the ALU's carry and overflow flags together with result-derived N/Z, and handles BIT, PLP/RTI loads and explicit flag set/clear. It also supplies the carry-in back to the ALU and the push image for PHP/BRK/interrupt entry, plus an IRQ mask with 6502-style one-cycle lag.

---
 rtl/status_reg.sv | 116 +++++++++++
 tb/tb_status_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/status_reg.sv
// 6502 processor-status (P) register: six stored flags, push image and IRQ mask.
// Optional macro STATUS_IRQ_DELAY_EN adds a register stage on irq_mask_o (6502 CLI/SEI lag).
module status_reg (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] op_i,
  input  logic [7:0] mask_i,
  input  logic       alu_carry_i,
  input  logic       alu_overflow_i,
  input  logic [7:0] nz_val_i,
  input  logic [7:0] db_i,
  input  logic       push_brk_i,
  output logic [7:0] p_o,
  output logic [7:0] p_push_o,
  output logic       c_o,
  output logic       irq_mask_o
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ALU  = 3'd1;
  localparam logic [2:0] OP_BIT  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_SET  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;

  logic flag_c, flag_z, flag_i, flag_d, flag_v, flag_n;
  logic next_c, next_z, next_i, next_d, next_v, next_n;
  logic nz_zero;

  assign nz_zero = (nz_val_i == 8'h00);

  always_comb begin
    next_c = flag_c;
    next_z = flag_z;
    next_i = flag_i;
    next_d = flag_d;
    next_v = flag_v;
    next_n = flag_n;
    case (op_i)
      OP_ALU: begin
        // I and D are never written by the ALU path, whatever the mask says.
        if (mask_i[0]) next_c = alu_carry_i;
        if (mask_i[1]) next_z = nz_zero;
        if (mask_i[6]) next_v = alu_overflow_i;
        if (mask_i[7]) next_n = nz_val_i[7];
      end
      OP_BIT: begin
        next_n = db_i[7];
        next_v = db_i[6];
        next_z = nz_zero;
      end
      OP_LOAD: begin
        next_c = db_i[0];
        next_z = db_i[1];
        next_i = db_i[2];
        next_d = db_i[3];
        next_v = db_i[6];
        next_n = db_i[7];
      end
      OP_SET: begin
        if (mask_i[0]) next_c = 1'b1;
        if (mask_i[1]) next_z = 1'b1;
        if (mask_i[2]) next_i = 1'b1;
        if (mask_i[3]) next_d = 1'b1;
        if (mask_i[6]) next_v = 1'b1;
        if (mask_i[7]) next_n = 1'b1;
      end
      OP_CLR: begin
        if (mask_i[0]) next_c = 1'b0;
        if (mask_i[1]) next_z = 1'b0;
        if (mask_i[2]) next_i = 1'b0;
        if (mask_i[3]) next_d = 1'b0;
        if (mask_i[6]) next_v = 1'b0;
        if (mask_i[7]) next_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_i <= 1'b1;
      flag_d <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      flag_c <= next_c;
      flag_z <= next_z;
      flag_i <= next_i;
      flag_d <= next_d;
      flag_v <= next_v;
      flag_n <= next_n;
    end
  end

  assign p_o      = {flag_n, flag_v, 1'b1, 1'b0, flag_d, flag_i, flag_z, flag_c};
  assign p_push_o = {flag_n, flag_v, 1'b1, push_brk_i, flag_d, flag_i, flag_z, flag_c};
  assign c_o      = flag_c;

`ifdef STATUS_IRQ_DELAY_EN
  // Polling one cycle after CLI/SEI still sees the previous mask.
  logic irq_mask_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_mask_q <= 1'b1;
    else       irq_mask_q <= flag_i;
  end

  assign irq_mask_o = irq_mask_q;
`else
  assign irq_mask_o = flag_i;
`endif

endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: directed cases plus randomized ops against a byte-level P model.
module tb_status_reg;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] op_i;
  logic [7:0] mask_i;
  logic       alu_carry_i;
  logic       alu_overflow_i;
  logic [7:0] nz_val_i;
  logic [7:0] db_i;
  logic       push_brk_i;
  logic [7:0] p_o;
  logic [7:0] p_push_o;
  logic       c_o;
  logic       irq_mask_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] p_m;
  logic       irq_m;

  status_reg dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .op_i           (op_i),
    .mask_i         (mask_i),
    .alu_carry_i    (alu_carry_i),
    .alu_overflow_i (alu_overflow_i),
    .nz_val_i       (nz_val_i),
    .db_i           (db_i),
    .push_brk_i     (push_brk_i),
    .p_o            (p_o),
    .p_push_o       (p_push_o),
    .c_o            (c_o),
    .irq_mask_o     (irq_mask_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // Reference: P as a byte, bit5 always 1, bit4 never stored.
  function automatic logic [7:0] model_apply(input logic [7:0] p, input logic [2:0] op,
                                             input logic [7:0] mask, input logic carry,
                                             input logic ov, input logic [7:0] nz,
                                             input logic [7:0] db);
    logic [7:0] m;
    logic [7:0] v;
    logic [7:0] r;
    r = p;
    case (op)
      3'd1: begin
        m = mask & 8'hC3;
        v = {nz[7], ov, 4'b0000, (nz == 8'h00), carry};
        r = (p & ~m) | (v & m);
      end
      3'd2: begin
        m = 8'hC2;
        v = {db[7], db[6], 4'b0000, (nz == 8'h00), 1'b0};
        r = (p & ~m) | (v & m);
      end
      3'd3: r = (db & 8'hCF) | 8'h20;
      3'd4: r = p | (mask & 8'hCF);
      3'd5: r = p & ~(mask & 8'hCF);
      default: r = p;
    endcase
    return r;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".p"}, p_o, p_m);
    check({tag, ".c"}, {7'd0, c_o}, {7'd0, p_m[0]});
    check({tag, ".irq"}, {7'd0, irq_mask_o}, {7'd0, irq_m});
    check({tag, ".push"}, p_push_o, (p_m & 8'hEF) | {3'b000, push_brk_i, 4'b0000});
  endtask

  // driver: inputs set at negedge, model advanced at posedge, outputs checked at next negedge
  task automatic do_op(input logic [2:0] op, input logic [7:0] mask, input logic carry,
                       input logic ov, input logic [7:0] nz, input logic [7:0] db);
    logic old_i;
    op_i = op; mask_i = mask; alu_carry_i = carry; alu_overflow_i = ov;
    nz_val_i = nz; db_i = db;
    @(posedge clk_i);
    old_i = p_m[2];
    p_m = model_apply(p_m, op, mask, carry, ov, nz, db);
`ifdef STATUS_IRQ_DELAY_EN
    irq_m = old_i;
`else
    irq_m = p_m[2];
`endif
    @(negedge clk_i);
  endtask

  task automatic nop();
    do_op(3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    p_m = 8'h24;
    irq_m = 1'b1;
    #1;
    check_all("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; op_i = 3'd0; mask_i = 8'h00; alu_carry_i = 1'b0; alu_overflow_i = 1'b0;
    nz_val_i = 8'h00; db_i = 8'h00; push_brk_i = 1'b0;
    p_m = 8'h24; irq_m = 1'b1;
    @(negedge clk_i);
    check_all("por");
    check("por_p", p_o, 8'h24);
    rst_i = 1'b0;

    // reset asserted mid-cycle with P = E7
    do_op(3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'hE7);
    nop();
    check("load_e7", p_o, 8'hE7);
    @(posedge clk_i);
    #2;
    do_reset();
    check("rst_p", p_o, 8'h24);
    check("rst_c", {7'd0, c_o}, 8'h00);
    check("rst_irq", {7'd0, irq_mask_o}, 8'h01);

    // ALU masking
    do_op(3'd1, 8'hC3, 1'b1, 1'b1, 8'h80, 8'h00);
    check("alu_c3", p_o, 8'hE5);
    check_all("alu_c3");
    do_op(3'd1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00);
    check("alu_03", p_o, 8'hE7);
    check("alu_chain_c", {7'd0, c_o}, 8'h01);
    do_op(3'd1, 8'h3C, 1'b0, 1'b0, 8'h01, 8'h00);
    check("alu_id_ignored", p_o, 8'hE7);

    // BIT
    do_op(3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h24);
    do_op(3'd2, 8'h00, 1'b1, 1'b1, 8'h00, 8'hC0);
    check("bit_c0", p_o, 8'hE6);
    do_op(3'd2, 8'hFF, 1'b1, 1'b1, 8'h01, 8'h00);
    check("bit_00", p_o, 8'h24);

    // LOAD FF and push image
    do_op(3'd3, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF);
    check("load_ff", p_o, 8'hEF);
    push_brk_i = 1'b1; #1;
    check("push_brk1", p_push_o, 8'hFF);
    push_brk_i = 1'b0; #1;
    check("push_brk0", p_push_o, 8'hEF);

    // IRQ lag from reset
    @(negedge clk_i);
    do_reset();
    do_op(3'd5, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00);
    check("cli_p", p_o, 8'h20);
`ifdef STATUS_IRQ_DELAY_EN
    check("cli_irq_n1", {7'd0, irq_mask_o}, 8'h01);
`else
    check("cli_irq_n1", {7'd0, irq_mask_o}, 8'h00);
`endif
    nop();
    check("cli_irq_n2", {7'd0, irq_mask_o}, 8'h00);
    do_op(3'd4, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00);
    nop();
    check("sei_irq", {7'd0, irq_mask_o}, 8'h01);

    // SET/CLR and reserved
    do_op(3'd5, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
    check("clr_ff", p_o, 8'h20);
    do_op(3'd4, 8'h08, 1'b0, 1'b0, 8'h00, 8'h00);
    check("set_08", p_o, 8'h28);
    do_op(3'd7, 8'hFF, 1'b1, 1'b1, 8'h80, 8'hFF);
    check("op7", p_o, 8'h28);
    do_op(3'd6, 8'hFF, 1'b1, 1'b1, 8'h00, 8'hFF);
    check("op6", p_o, 8'h28);
    do_op(3'd4, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check("set_m0", p_o, 8'h28);
    do_op(3'd5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check("clr_m0", p_o, 8'h28);

    // randomized ops against the model
    for (int k = 0; k < 400; k++) begin
      push_brk_i = 1'($urandom_range(0, 1));
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            8'($urandom));
      check_all("rand");
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk_i);
        #3;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
